// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one memory-mapped IO bus among several requesters.
// Issues one transaction at a time and routes read data back to the issuing requester.
module io_arbiter #(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned READ_LATENCY   = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQUESTERS-1:0]        req_valid,
   input  logic [NUM_REQUESTERS-1:0]        req_write,
   input  logic [NUM_REQUESTERS*32-1:0]     req_address,
   input  logic [NUM_REQUESTERS*32-1:0]     req_write_data,
   output logic [NUM_REQUESTERS-1:0]        req_grant,
   output logic [NUM_REQUESTERS-1:0]        resp_valid,
   output logic [31:0]                      resp_data,
   output logic                             io_write_en,
   output logic                             io_read_en,
   output logic [31:0]                      io_address,
   output logic [31:0]                      io_write_data,
   input  logic [31:0]                      io_read_data
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      READ_WAIT = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    last_grant;
   logic [IDX_W-1:0]    owner;
   logic [CNT_W-1:0]    wait_cnt;

   logic                pick_found;
   logic [IDX_W-1:0]    pick_idx;
   logic [IDX_W-1:0]    cand;
   logic                accept_c;
   logic                sel_write_c;
   logic [DATA_W-1:0]   sel_address_c;
   logic [DATA_W-1:0]   sel_write_data_c;
   logic                sample_c;

   // Round-robin search starting one past the last accepted requester.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
         cand = IDX_W'((32'(last_grant) + k + 32'd1) % NUM_REQUESTERS);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Grant is suppressed in reset and while a read is outstanding.
   always_comb begin
      req_grant = '0;
      if (!reset && (state == IDLE) && pick_found) begin
         req_grant[pick_idx] = 1'b1;
      end
   end

   always_comb begin
      accept_c         = |(req_valid & req_grant);
      sel_write_c      = req_write[pick_idx];
      sel_address_c    = req_address[pick_idx*DATA_W +: DATA_W];
      sel_write_data_c = req_write_data[pick_idx*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      sample_c   = 1'b0;
      case (state)
         IDLE: begin
            if (accept_c && !sel_write_c) begin
               state_next = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (wait_cnt == '0) begin
               state_next = IDLE;
               sample_c   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus strobes, latched payload, wait counter and response path.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant    <= IDX_W'(NUM_REQUESTERS - 1);
         owner         <= '0;
         wait_cnt      <= '0;
         io_write_en   <= 1'b0;
         io_read_en    <= 1'b0;
         io_address    <= '0;
         io_write_data <= '0;
         resp_valid    <= '0;
         resp_data     <= '0;
      end else begin
         io_write_en <= 1'b0;
         io_read_en  <= 1'b0;
         resp_valid  <= '0;
         if (accept_c) begin
            last_grant <= pick_idx;
            io_address <= sel_address_c;
            if (sel_write_c) begin
               io_write_en   <= 1'b1;
               io_write_data <= sel_write_data_c;
            end else begin
               io_read_en <= 1'b1;
               owner      <= pick_idx;
               wait_cnt   <= CNT_W'(READ_LATENCY);
            end
         end else if ((state == READ_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
         if (sample_c) begin
            resp_data  <= io_read_data;
            resp_valid <= NUM_REQUESTERS'(1) << owner;
         end
      end
   end

endmodule
